// File: rtl/wb_initiator_if.sv
// Wishbone B4 pipelined bus bundle between the initiator and the interconnect.
//
// Handshake semantics: a bus request is presented while wb_cyc_o and wb_stb_o
// are both high; it is taken by the slave on any rising edge where wb_stall_i
// is low. The cycle ends on the first edge where wb_ack_i, wb_err_i or
// wb_rty_i is high while wb_cyc_o is high (ack beats err beats rty). There is
// no backpressure on termination.
interface wb_initiator_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  wb_cyc_o;
   logic                  wb_stb_o;
   logic                  wb_we_o;
   logic [ADDR_WIDTH-1:0] wb_adr_o;
   logic [3:0]            wb_sel_o;
   logic [31:0]           wb_dat_o;
   logic [31:0]           wb_dat_i;
   logic                  wb_ack_i;
   logic                  wb_err_i;
   logic                  wb_rty_i;
   logic                  wb_stall_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
      input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
      output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
   );
endinterface

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone B4 pipelined initiator. Converts one host
// request at a time into a bus cycle, handles stall, ack/err/rty, a
// per-attempt timeout and bounded retry, and returns a status with the data.
//
// Host handshake: a request is taken on a rising edge where req_i and
// req_ready_o are both high; requests while not ready are dropped. The
// response is a single-cycle rsp_valid_o pulse with no backpressure.
module wb_initiator #(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255,
   parameter int MAX_RETRY  = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  req_i,
   input  logic                  req_we_i,
   input  logic [ADDR_WIDTH-1:0] req_adr_i,
   input  logic [31:0]           req_dat_i,
   input  logic [3:0]            req_sel_i,
   output logic                  req_ready_o,
   output logic                  rsp_valid_o,
   output logic [31:0]           rsp_dat_o,
   output logic [1:0]            rsp_status_o,
   output logic [2:0]            dbg_state_o,
   wb_initiator_if.master        wb
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STROBE = 3'd1,
      WAIT   = 3'd2,
      RETRY  = 3'd3,
      RESP   = 3'd4
   } state_e;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_ERR     = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_RTY     = 2'b11;

   // Timeout counter only needs to reach TIMEOUT-1 before the attempt ends.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [RW-1:0] RTY_LIMIT = RW'(MAX_RETRY);

   state_e                state_q, state_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic [RW-1:0]         rty_q, rty_d;

   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [31:0]           dat_q, dat_d;
   logic [3:0]            sel_q, sel_d;

   logic                  cyc_q, cyc_d;
   logic                  stb_q, stb_d;
   logic                  ready_q, ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [31:0]           rsp_dat_q, rsp_dat_d;
   logic [1:0]            rsp_status_q, rsp_status_d;

   logic                  active;
   logic                  accept;
   logic                  term_ack;
   logic                  term_err;
   logic                  term_rty;
   logic                  timed_out;
   logic                  retry_ok;

   // Decode the termination of the current attempt with ack > err > rty.
   always_comb begin
      active    = (state_q == STROBE) || (state_q == WAIT);
      accept    = (state_q == IDLE) && req_i && ready_q;
      term_ack  = active && wb.wb_ack_i;
      term_err  = active && !wb.wb_ack_i && wb.wb_err_i;
      term_rty  = active && !wb.wb_ack_i && !wb.wb_err_i && wb.wb_rty_i;
      timed_out = active && !(wb.wb_ack_i || wb.wb_err_i || wb.wb_rty_i) &&
                  (tmo_q == TMO_LAST);
      retry_ok  = (rty_q < RTY_LIMIT);
   end

   // State register plus all registered outputs and datapath.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         tmo_q        <= '0;
         rty_q        <= '0;
         we_q         <= 1'b0;
         adr_q        <= '0;
         dat_q        <= '0;
         sel_q        <= '0;
         cyc_q        <= 1'b0;
         stb_q        <= 1'b0;
         ready_q      <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_dat_q    <= '0;
         rsp_status_q <= ST_OK;
      end else begin
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         rty_q        <= rty_d;
         we_q         <= we_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         sel_q        <= sel_d;
         cyc_q        <= cyc_d;
         stb_q        <= stb_d;
         ready_q      <= ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_dat_q    <= rsp_dat_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   // Next-state logic: request acceptance, stall, termination and timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = STROBE;
         end
         STROBE: begin
            if (term_ack || term_err)  state_d = RESP;
            else if (term_rty)         state_d = retry_ok ? RETRY : RESP;
            else if (timed_out)        state_d = RESP;
            else if (!wb.wb_stall_i)   state_d = WAIT;
         end
         WAIT: begin
            if (term_ack || term_err)  state_d = RESP;
            else if (term_rty)         state_d = retry_ok ? RETRY : RESP;
            else if (timed_out)        state_d = RESP;
         end
         RETRY:   state_d = STROBE;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counters and the latched request; the request is held across retries.
   always_comb begin
      tmo_d = tmo_q;
      rty_d = rty_q;
      we_d  = we_q;
      adr_d = adr_q;
      dat_d = dat_q;
      sel_d = sel_q;

      if (accept || state_q == RETRY) tmo_d = '0;
      else if (active)                tmo_d = tmo_q + TW'(1);

      if (state_q == RESP)            rty_d = '0;
      else if (term_rty && retry_ok)  rty_d = rty_q + RW'(1);

      if (accept) begin
         we_d  = req_we_i;
         adr_d = req_adr_i;
         dat_d = req_dat_i;
         sel_d = req_sel_i;
      end
   end

   // Output logic: bus and host outputs are derived from the next state so
   // they change on the same edge as the state itself.
   always_comb begin
      cyc_d        = (state_d == STROBE) || (state_d == WAIT);
      stb_d        = (state_d == STROBE);
      ready_d      = (state_d == IDLE);
      rsp_valid_d  = (state_d == RESP);
      rsp_dat_d    = rsp_dat_q;
      rsp_status_d = rsp_status_q;

      if (active && state_d == RESP) begin
         rsp_dat_d = '0;
         if (term_ack) begin
            rsp_status_d = ST_OK;
            if (!we_q) rsp_dat_d = wb.wb_dat_i;
         end else if (term_err) begin
            rsp_status_d = ST_ERR;
         end else if (term_rty) begin
            rsp_status_d = ST_RTY;
         end else begin
            rsp_status_d = ST_TIMEOUT;
         end
      end
   end

   assign wb.wb_cyc_o  = cyc_q;
   assign wb.wb_stb_o  = stb_q;
   assign wb.wb_we_o   = we_q;
   assign wb.wb_adr_o  = adr_q;
   assign wb.wb_sel_o  = sel_q;
   assign wb.wb_dat_o  = dat_q;

   assign req_ready_o  = ready_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_dat_o    = rsp_dat_q;
   assign rsp_status_o = rsp_status_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator with a cycle-stepped slave model and
// monitor. TIMEOUT=8, MAX_RETRY=2.
module tb_wb_initiator;

   localparam int T_NONE = 0;
   localparam int T_ACK  = 1;
   localparam int T_ERR  = 2;
   localparam int T_RTY  = 3;
   localparam int T_AE   = 4;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_n_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic        req_i = 1'b0;
   logic        req_we_i = 1'b0;
   logic [31:0] req_adr_i = '0;
   logic [31:0] req_dat_i = '0;
   logic [3:0]  req_sel_i = '0;
   logic        req_ready_o;
   logic        rsp_valid_o;
   logic [31:0] rsp_dat_o;
   logic [1:0]  rsp_status_o;
   logic [2:0]  dbg_state_o;

   wb_initiator_if #(.ADDR_WIDTH(32)) wb ();

   wb_initiator #(.ADDR_WIDTH(32), .TIMEOUT(8), .MAX_RETRY(2)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .req_i        (req_i),
      .req_we_i     (req_we_i),
      .req_adr_i    (req_adr_i),
      .req_dat_i    (req_dat_i),
      .req_sel_i    (req_sel_i),
      .req_ready_o  (req_ready_o),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_dat_o    (rsp_dat_o),
      .rsp_status_o (rsp_status_o),
      .dbg_state_o  (dbg_state_o),
      .wb           (wb)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_pass   = 0;

   int          cfg_stall;
   int          cfg_lat;
   int          cfg_term [4];
   logic [31:0] cfg_rdata;

   int          stb_cnt, cyc_cnt, gap_cnt, att_cnt, rsp_cnt, s_age, lat;
   logic        s_in_cyc, in_txn, adr_moved;
   logic [31:0] seen_adr, seen_dat, last_rsp_dat;
   logic [3:0]  seen_sel;
   logic        seen_we;
   logic [1:0]  last_rsp_st;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic set_slave(input int stall, input int lat_c, input int t0, input int t1,
                            input int t2, input int t3, input logic [31:0] rdata);
      cfg_stall   = stall;
      cfg_lat     = lat_c;
      cfg_term[0] = t0;
      cfg_term[1] = t1;
      cfg_term[2] = t2;
      cfg_term[3] = t3;
      cfg_rdata   = rdata;
   endtask

   task automatic clear_mon();
      stb_cnt = 0; cyc_cnt = 0; gap_cnt = 0; att_cnt = 0; rsp_cnt = 0;
      s_age = 0; s_in_cyc = 1'b0; in_txn = 1'b0; adr_moved = 1'b0;
      seen_adr = '0; seen_dat = '0; seen_sel = '0; seen_we = 1'b0;
      last_rsp_dat = '0; last_rsp_st = '0;
   endtask

   // One clock: observe at the falling edge, then drive the slave response
   // for the next rising edge.
   task automatic cycle();
      int t;
      @(negedge clk_i);
      if (rsp_valid_o) begin
         rsp_cnt++;
         last_rsp_dat = rsp_dat_o;
         last_rsp_st  = rsp_status_o;
         in_txn       = 1'b0;
      end
      if (wb.wb_cyc_o) cyc_cnt++;
      if (wb.wb_stb_o) begin
         if (stb_cnt > 0 && wb.wb_adr_o != seen_adr) adr_moved = 1'b1;
         stb_cnt++;
         seen_adr = wb.wb_adr_o;
         seen_dat = wb.wb_dat_o;
         seen_sel = wb.wb_sel_o;
         seen_we  = wb.wb_we_o;
      end
      if (!wb.wb_cyc_o && in_txn && !rsp_valid_o) gap_cnt++;

      wb.wb_ack_i   = 1'b0;
      wb.wb_err_i   = 1'b0;
      wb.wb_rty_i   = 1'b0;
      wb.wb_stall_i = 1'b0;
      wb.wb_dat_i   = '0;
      if (wb.wb_cyc_o) begin
         if (!s_in_cyc) begin
            s_in_cyc = 1'b1;
            s_age    = 0;
            att_cnt++;
            in_txn   = 1'b1;
         end else begin
            s_age++;
         end
         if (s_age < cfg_stall) wb.wb_stall_i = 1'b1;
         if (s_age == cfg_stall + cfg_lat) begin
            t = (att_cnt >= 1 && att_cnt <= 4) ? cfg_term[att_cnt-1] : T_NONE;
            case (t)
               T_ACK: begin wb.wb_ack_i = 1'b1; wb.wb_dat_i = cfg_rdata; end
               T_ERR: wb.wb_err_i = 1'b1;
               T_RTY: wb.wb_rty_i = 1'b1;
               T_AE:  begin wb.wb_ack_i = 1'b1; wb.wb_err_i = 1'b1; wb.wb_dat_i = cfg_rdata; end
               default: ;
            endcase
         end
      end else begin
         s_in_cyc = 1'b0;
      end
   endtask

   // Issue one request and wait (bounded) for its response pulse.
   task automatic do_req(input string tag, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
      int n;
      clear_mon();
      n = 0;
      while (!req_ready_o && n < 50) begin cycle(); n++; end
      check({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
      req_i = 1'b1; req_we_i = we; req_adr_i = adr; req_dat_i = dat; req_sel_i = sel;
      cycle();
      req_i = 1'b0;
      lat = 1;
      while (rsp_cnt == 0 && lat < 100) begin cycle(); lat++; end
      check({tag, "_rsp_seen"}, rsp_cnt, 32'd1);
      cycle();
      check({tag, "_rsp_pulse"}, {31'd0, rsp_valid_o}, 32'd0);
      check({tag, "_ready_after"}, {31'd0, req_ready_o}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0;
      wb.wb_stall_i = 1'b0; wb.wb_dat_i = '0;
      set_slave(0, 0, T_NONE, T_NONE, T_NONE, T_NONE, 32'd0);
      clear_mon();

      // ---- reset state ----
      repeat (3) cycle();
      check("rst_ready", {31'd0, req_ready_o}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      check("rst_rsp_dat", rsp_dat_o, 32'd0);
      check("rst_rsp_status", {30'd0, rsp_status_o}, 32'd0);
      check("rst_cyc_stb", {30'd0, wb.wb_cyc_o, wb.wb_stb_o}, 32'd0);
      check("rst_adr", wb.wb_adr_o, 32'd0);
      check("rst_dat_we_sel", {wb.wb_dat_o[26:0], wb.wb_we_o, wb.wb_sel_o}, 32'd0);
      rst_n_i = 1'b1;
      #1 check("rel_ready_before_edge", {31'd0, req_ready_o}, 32'd0);
      cycle();
      check("rel_ready_first_edge", {31'd0, req_ready_o}, 32'd1);

      // ---- write, ack two cycles after the strobe is taken ----
      set_slave(0, 2, T_ACK, T_NONE, T_NONE, T_NONE, 32'hFFFF_FFFF);
      do_req("wr", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      check("wr_stb_cycles", stb_cnt, 32'd1);
      check("wr_cyc_cycles", cyc_cnt, 32'd3);
      check("wr_dat", seen_dat, 32'hDEAD_BEEF);
      check("wr_adr", seen_adr, 32'h10);
      check("wr_we_sel", {27'd0, seen_we, seen_sel}, 32'h1F);
      check("wr_status", {30'd0, last_rsp_st}, 32'd0);
      check("wr_rsp_dat", last_rsp_dat, 32'd0);
      check("wr_latency", lat, 32'd4);

      // ---- read with 3 stall cycles ----
      set_slave(3, 0, T_ACK, T_NONE, T_NONE, T_NONE, 32'h0000_000C);
      do_req("rd_stall", 1'b0, 32'h04, 32'h0, 4'hF);
      check("rd_stall_stb_cycles", stb_cnt, 32'd4);
      check("rd_stall_adr_stable", {31'd0, adr_moved}, 32'd0);
      check("rd_stall_adr", seen_adr, 32'h04);
      check("rd_stall_we", {31'd0, seen_we}, 32'd0);
      check("rd_stall_dat", last_rsp_dat, 32'h0000_000C);
      check("rd_stall_status", {30'd0, last_rsp_st}, 32'd0);
      check("rd_stall_latency", lat, 32'd5);

      // ---- ack and err together: ack wins ----
      set_slave(0, 1, T_AE, T_NONE, T_NONE, T_NONE, 32'h1234_5678);
      do_req("ack_err", 1'b0, 32'h08, 32'h0, 4'h3);
      check("ack_err_status", {30'd0, last_rsp_st}, 32'd0);
      check("ack_err_dat", last_rsp_dat, 32'h1234_5678);

      // ---- err alone, terminated in the strobe cycle (minimum latency) ----
      set_slave(0, 0, T_ERR, T_NONE, T_NONE, T_NONE, 32'h5555_AAAA);
      do_req("err", 1'b0, 32'h0C, 32'h0, 4'hF);
      check("err_status", {30'd0, last_rsp_st}, 32'd1);
      check("err_dat", last_rsp_dat, 32'd0);
      check("err_latency", lat, 32'd2);

      // ---- no termination: timeout after 8 cyc cycles ----
      set_slave(0, 0, T_NONE, T_NONE, T_NONE, T_NONE, 32'h0);
      do_req("tmo", 1'b0, 32'h20, 32'h0, 4'hF);
      check("tmo_cyc_cycles", cyc_cnt, 32'd8);
      check("tmo_status", {30'd0, last_rsp_st}, 32'd2);
      check("tmo_dat", last_rsp_dat, 32'd0);

      set_slave(0, 0, T_ACK, T_NONE, T_NONE, T_NONE, 32'hCAFE_0001);
      do_req("post_tmo", 1'b0, 32'h24, 32'h0, 4'hF);
      check("post_tmo_status", {30'd0, last_rsp_st}, 32'd0);
      check("post_tmo_dat", last_rsp_dat, 32'hCAFE_0001);

      // ---- rty on every attempt: 3 strobes, then exhausted ----
      set_slave(0, 0, T_RTY, T_RTY, T_RTY, T_RTY, 32'h7777_7777);
      do_req("rty_all", 1'b0, 32'h30, 32'h0, 4'hF);
      check("rty_all_attempts", att_cnt, 32'd3);
      check("rty_all_stb_cycles", stb_cnt, 32'd3);
      check("rty_all_gaps", gap_cnt, 32'd2);
      check("rty_all_status", {30'd0, last_rsp_st}, 32'd3);
      check("rty_all_dat", last_rsp_dat, 32'd0);

      // ---- rty then ack: 2 strobes, ok ----
      set_slave(0, 0, T_RTY, T_ACK, T_NONE, T_NONE, 32'hBEEF_0002);
      do_req("rty_ack", 1'b0, 32'h34, 32'h0, 4'hF);
      check("rty_ack_attempts", att_cnt, 32'd2);
      check("rty_ack_gaps", gap_cnt, 32'd1);
      check("rty_ack_status", {30'd0, last_rsp_st}, 32'd0);
      check("rty_ack_dat", last_rsp_dat, 32'hBEEF_0002);

      // ---- reset while in WAIT ----
      set_slave(0, 0, T_NONE, T_NONE, T_NONE, T_NONE, 32'h0);
      clear_mon();
      req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h40; req_sel_i = 4'hF;
      cycle();
      req_i = 1'b0;
      cycle();
      check("wait_cyc_stb", {30'd0, wb.wb_cyc_o, wb.wb_stb_o}, 32'd2);
      rst_n_i = 1'b0;
      #1;
      check("arst_cyc_stb", {30'd0, wb.wb_cyc_o, wb.wb_stb_o}, 32'd0);
      check("arst_ready", {31'd0, req_ready_o}, 32'd0);
      repeat (3) cycle();
      check("arst_no_rsp", rsp_cnt, 32'd0);
      rst_n_i = 1'b1;
      cycle();
      check("arst_ready_after", {31'd0, req_ready_o}, 32'd1);
      check("arst_no_rsp_after", rsp_cnt, 32'd0);

      set_slave(1, 1, T_ACK, T_NONE, T_NONE, T_NONE, 32'hA5A5_0001);
      do_req("post_rst", 1'b0, 32'h44, 32'h0, 4'hF);
      check("post_rst_status", {30'd0, last_rsp_st}, 32'd0);
      check("post_rst_dat", last_rsp_dat, 32'hA5A5_0001);
      check("post_rst_adr", seen_adr, 32'h44);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
